// File: rtl/inst_exec_if.sv
// Executor bus bundle: controller handshake, program ROM port, unit req/ack
// and the status flags. 'slave' is the executor side, 'master' is the
// controller/ROM/unit environment side.
interface inst_exec_if #(
    parameter int NUNIT = 4,
    parameter int ARGW  = 10
);
    logic             inst_valid;
    logic [7:0]       pc;
    logic [1:0]       level;
    logic             inst_done;
    logic             rom_en;
    logic [7:0]       rom_addr;
    logic [15:0]      rom_data;
    logic [NUNIT-1:0] unit_req;
    logic [ARGW-1:0]  unit_arg;
    logic [7:0]       unit_idx;
    logic [NUNIT-1:0] unit_ack;
    logic             busy;
    logic             illegal;
    logic             overrun;

    modport slave (
        input  inst_valid, pc, level, rom_data, unit_ack,
        output inst_done, rom_en, rom_addr, unit_req, unit_arg, unit_idx,
               busy, illegal, overrun
    );

    modport master (
        output inst_valid, pc, level, rom_data, unit_ack,
        input  inst_done, rom_en, rom_addr, unit_req, unit_arg, unit_idx,
               busy, illegal, overrun
    );
endinterface

// File: rtl/inst_exec.sv
// Instruction executor: fetch one ROM word, decode NOP/ISSUE/LOOP, drive
// one or N unit requests with a one-cycle gap between them, then pulse
// inst_done. Every output is a register or a decode of the state register,
// so nothing here is combinational from an input.
module inst_exec #(
    parameter int NUNIT = 4,   // unit field is 2 bits, so this must stay 4
    parameter int ARGW  = 10   // at most the 10-bit argument field
) (
    input  logic        clk,
    input  logic        rst,
    inst_exec_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_GAP, S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ISSUE = 4'd1;
    localparam logic [3:0] OP_LOOP  = 4'd2;

    state_t      state_q, state_d;
    logic [7:0]  pc_q;
    logic [1:0]  level_q;
    logic [11:0] ir_q;       // unit select + argument; opcode is consumed at decode
    logic        loop_q;     // decoded instruction was LOOP rather than ISSUE
    logic [7:0]  idx_q;
    logic        illegal_q;
    logic        overrun_q;

    logic [3:0]  rom_op;
    logic [1:0]  sel;
    logic        ack_sel;
    logic [7:0]  lvl_last;
    logic [7:0]  last_idx;
    logic        at_last;

    assign rom_op  = bus.rom_data[15:12];
    assign sel     = ir_q[11:10];
    assign ack_sel = bus.unit_ack[sel];

    // Last LOOP index (N-1) for the level latched at accept time.
    always_comb begin
        lvl_last = 8'd79;
        case (level_q)
            2'd0:    lvl_last = 8'd79;
            2'd1:    lvl_last = 8'd121;
            2'd2:    lvl_last = 8'd167;
            default: lvl_last = 8'd79;
        endcase
    end

    assign last_idx = loop_q ? lvl_last : 8'd0;
    assign at_last  = (idx_q == last_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; DECODE looks at the ROM word arriving this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.inst_valid) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (rom_op == OP_ISSUE || rom_op == OP_LOOP) state_d = S_ISSUE;
                else                                         state_d = S_DONE;
            end
            S_ISSUE:  if (ack_sel) state_d = at_last ? S_DONE : S_GAP;
            S_GAP:    state_d = S_ISSUE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from state and registered datapath only.
    always_comb begin
        bus.rom_en    = (state_q == S_FETCH);
        bus.inst_done = (state_q == S_DONE);
        bus.busy      = (state_q != S_IDLE);
        bus.unit_req  = '0;
        if (state_q == S_ISSUE)
            bus.unit_req = {{(NUNIT-1){1'b0}}, 1'b1} << sel;
        bus.rom_addr  = pc_q;
        bus.unit_arg  = ir_q[ARGW-1:0];
        bus.unit_idx  = idx_q;
        bus.illegal   = illegal_q;
        bus.overrun   = overrun_q;
    end

    // Datapath: accept latch, instruction register, iteration index, sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            level_q   <= '0;
            ir_q      <= '0;
            loop_q    <= 1'b0;
            idx_q     <= '0;
            illegal_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && bus.inst_valid) begin
                pc_q    <= bus.pc;
                level_q <= bus.level;
            end
            // A pulse outside IDLE (including the DONE cycle) is dropped.
            if (state_q != S_IDLE && bus.inst_valid)
                overrun_q <= 1'b1;
            if (state_q == S_DECODE) begin
                ir_q   <= bus.rom_data[11:0];
                loop_q <= (rom_op == OP_LOOP);
                idx_q  <= '0;
                if (rom_op != OP_NOP && rom_op != OP_ISSUE && rom_op != OP_LOOP)
                    illegal_q <= 1'b1;
            end
            if (state_q == S_ISSUE && ack_sel && !at_last)
                idx_q <= idx_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_exec.sv
// Directed bench for inst_exec: ROM model, manual/auto unit acks, linear
// sequence of steps with immediate assertions at each comparison point.
module tb_inst_exec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_exec_if #(.NUNIT(4), .ARGW(10)) bus ();

    inst_exec #(.NUNIT(4), .ARGW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [15:0] rom [256];
    logic        auto_ack = 1'b0;
    logic [3:0]  man_ack  = 4'b0000;

    // ROM read data arrives the cycle after rom_en.
    always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    assign bus.unit_ack = (auto_ack ? bus.unit_req : 4'b0000) | man_ack;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse inst_valid for one cycle; returns in cycle 1 after accept.
    task automatic start(input logic [7:0] pc, input logic [1:0] lvl);
        bus.inst_valid = 1'b1;
        bus.pc         = pc;
        bus.level      = lvl;
        tick();
        bus.inst_valid = 1'b0;
    endtask

    // Run a LOOP at ROM[1] with immediate acks and check pulse count/latency.
    task automatic run_loop(input logic [1:0] lvl, input int n, input string tag);
        int cyc = 1, done_cyc = 0, pulses = 0, bad_idx = 0, bad_req = 0, bad_gap = 0;
        logic prev = 1'b0;
        auto_ack = 1'b1;
        start(8'd1, lvl);
        for (int k = 0; k < 600; k++) begin
            if (bus.inst_done === 1'b1) begin done_cyc = cyc; break; end
            if (bus.unit_req !== 4'b0000) begin
                if (bus.unit_idx !== pulses[7:0]) bad_idx++;
                if (bus.unit_req !== 4'b0010) bad_req++;
                if (prev) bad_gap++;
                pulses++;
                prev = 1'b1;
            end else prev = 1'b0;
            tick();
            cyc++;
        end
        check({tag, "_pulses"}, pulses, n);
        check({tag, "_latency"}, done_cyc, 2*n + 2);
        check({tag, "_idx"}, bad_idx, 0);
        check({tag, "_req"}, bad_req, 0);
        check({tag, "_gap"}, bad_gap, 0);
        auto_ack = 1'b0;
        tick();
        check({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1C2A;
        rom[1] = 16'h2400;
        rom[2] = 16'h7000;
        rom[3] = 16'h1005;
        rom[5] = 16'h0000;
        bus.inst_valid = 1'b0;
        bus.pc         = 8'd0;
        bus.level      = 2'd0;

        // Reset state.
        tick(); tick();
        check("rst_done",    bus.inst_done, 1'b0);
        check("rst_rom_en",  bus.rom_en,    1'b0);
        check("rst_addr",    bus.rom_addr,  8'd0);
        check("rst_req",     bus.unit_req,  4'd0);
        check("rst_arg",     bus.unit_arg,  10'd0);
        check("rst_idx",     bus.unit_idx,  8'd0);
        check("rst_busy",    bus.busy,      1'b0);
        check("rst_illegal", bus.illegal,   1'b0);
        check("rst_overrun", bus.overrun,   1'b0);
        rst = 1'b0;
        tick();

        // NOP at pc 5.
        start(8'd5, 2'd0);
        check("nop_c1_rom_en", bus.rom_en, 1'b1);
        check("nop_c1_addr",   bus.rom_addr, 8'd5);
        check("nop_c1_busy",   bus.busy, 1'b1);
        tick();
        check("nop_c2_done",   bus.inst_done, 1'b0);
        check("nop_c2_req",    bus.unit_req, 4'd0);
        tick();
        check("nop_c3_done",   bus.inst_done, 1'b1);
        check("nop_c3_req",    bus.unit_req, 4'd0);
        tick();
        check("nop_c4_done",   bus.inst_done, 1'b0);
        check("nop_c4_busy",   bus.busy, 1'b0);

        // ISSUE unit 3, ack two cycles after the request.
        start(8'd0, 2'd0);
        tick();
        tick();
        check("iss_c3_req",  bus.unit_req, 4'b1000);
        check("iss_c3_arg",  bus.unit_arg, 10'h02A);
        check("iss_c3_idx",  bus.unit_idx, 8'd0);
        tick();
        check("iss_c4_req",  bus.unit_req, 4'b1000);
        check("iss_c4_done", bus.inst_done, 1'b0);
        tick();
        check("iss_c5_req",  bus.unit_req, 4'b1000);
        man_ack = 4'b1000;
        tick();
        man_ack = 4'b0000;
        check("iss_c6_done", bus.inst_done, 1'b1);
        check("iss_c6_req",  bus.unit_req, 4'd0);
        tick();

        // LOOP across levels.
        run_loop(2'd2, 168, "loop_l2");
        run_loop(2'd1, 122, "loop_l1");
        run_loop(2'd3, 80,  "loop_l3");

        // Illegal opcode, sticky across a NOP, cleared by reset.
        start(8'd2, 2'd0);
        tick();
        tick();
        check("ill_c3_done", bus.inst_done, 1'b1);
        check("ill_c3_flag", bus.illegal, 1'b1);
        tick();
        start(8'd5, 2'd0);
        tick(); tick(); tick();
        check("ill_sticky", bus.illegal, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("ill_cleared", bus.illegal, 1'b0);
        tick();

        // Overrun during ISSUE to unit 0, with a stray ack on unit 2.
        start(8'd3, 2'd0);
        tick();
        tick();
        check("ovr_c3_req", bus.unit_req, 4'b0001);
        man_ack        = 4'b0100;
        bus.inst_valid = 1'b1;
        bus.pc         = 8'd5;
        tick();
        bus.inst_valid = 1'b0;
        check("ovr_c4_req",    bus.unit_req, 4'b0001);
        check("ovr_c4_done",   bus.inst_done, 1'b0);
        check("ovr_c4_flag",   bus.overrun, 1'b1);
        check("ovr_c4_rom_en", bus.rom_en, 1'b0);
        man_ack = 4'b0001;
        tick();
        man_ack = 4'b0000;
        check("ovr_c5_done", bus.inst_done, 1'b1);
        check("ovr_c5_arg",  bus.unit_arg, 10'h005);
        tick();
        check("ovr_c6_busy",   bus.busy, 1'b0);
        check("ovr_c6_rom_en", bus.rom_en, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("ovr_cleared", bus.overrun, 1'b0);
        tick();

        // Overrun in the DONE cycle is not accepted.
        start(8'd5, 2'd0);
        tick();
        tick();
        check("ovd_c3_done", bus.inst_done, 1'b1);
        bus.inst_valid = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
        check("ovd_flag",   bus.overrun, 1'b1);
        check("ovd_busy",   bus.busy, 1'b0);
        tick();
        check("ovd_rom_en", bus.rom_en, 1'b0);
        check("ovd_busy2",  bus.busy, 1'b0);
        tick();

        // Reset in the middle of a LOOP at idx 40.
        begin
            logic hit = 1'b0;
            int   extra_done = 0;
            auto_ack = 1'b1;
            start(8'd1, 2'd2);
            for (int k = 0; k < 200; k++) begin
                if (bus.unit_req !== 4'd0 && bus.unit_idx === 8'd40) begin hit = 1'b1; break; end
                tick();
            end
            check("mid_reached40", hit, 1'b1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            auto_ack = 1'b0;
            check("mid_req",  bus.unit_req, 4'd0);
            check("mid_busy", bus.busy, 1'b0);
            check("mid_idx",  bus.unit_idx, 8'd0);
            check("mid_done", bus.inst_done, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tick();
                if (bus.inst_done !== 1'b0 || bus.busy !== 1'b0) extra_done++;
            end
            check("mid_quiet", extra_done, 0);
        end
        start(8'd5, 2'd0);
        check("post_c1_rom_en", bus.rom_en, 1'b1);
        tick();
        tick();
        check("post_c3_done", bus.inst_done, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_exec.md
# inst_exec

Instruction executor for the Frodo core sequencer. It is the responder side of the `inst_valid`/`pc` → `inst_done` handshake that the core controller drives. For each accepted `inst_valid` pulse it:

- fetches the 16-bit instruction at `pc` from the program ROM;
- decodes the instruction;
- issues one or a level-dependent number of requests to the functional units over a req/ack handshake;
- returns a single-cycle `inst_done` pulse.

## Interface

Parameters:
- `NUNIT`, 4: number of functional units; must be 4, because the unit field is 2 bits.
- `ARGW`, 10: width of the argument field passed to units.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `inst_valid`  in  1  one-cycle pulse that requests execution of the instruction at `pc`.
- `pc`  in  8  instruction address; sampled when `inst_valid` is accepted.
- `level`  in  2  security level; sampled with `pc`.
- `inst_done`  out  1  one-cycle completion pulse.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  8  ROM address.
- `rom_data`  in  16  ROM read data; valid 1 cycle after the `rom_en` cycle.
- `unit_req`  out  4  one-hot request to the selected unit.
- `unit_arg`  out  10  instruction argument field.
- `unit_idx`  out  8  current iteration index.
- `unit_ack`  in  4  per-unit acknowledge.
- `busy`  out  1  high in every state except IDLE.
- `illegal`  out  1  sticky flag: an illegal opcode was decoded.
- `overrun`  out  1  sticky flag: `inst_valid` arrived while busy.

## Operation

Instruction word fields:
- [15:12] opcode. 0 = NOP, 1 = ISSUE (single request), 2 = LOOP (repeated request). Opcodes 3–15 are illegal.
- [11:10] unit select.
- [9:0] argument.

LOOP iteration count N depends on the level latched at accept time:
- level 0 → 80
- level 1 → 122
- level 2 → 168
- level 3 → 80

`unit_idx` runs 0..N-1. For ISSUE, N = 1 and `unit_idx` = 0.

State machine (IDLE, FETCH, DECODE, ISSUE, GAP, DONE):
- IDLE:
  - `inst_valid` = 1 → latch `pc` and `level`, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: `rom_en` = 1, `rom_addr` = latched pc. Always go to DECODE.
- DECODE: latch `rom_data` into the instruction register and clear the iteration index.
  - NOP → DONE.
  - Illegal opcode → set `illegal`, go to DONE.
  - ISSUE or LOOP → go to ISSUE.
- ISSUE:
  - `unit_req[sel]` = 1; `unit_arg` and `unit_idx` are held stable.
  - `unit_ack[sel]` = 1 and idx = N-1 → DONE.
  - `unit_ack[sel]` = 1 and idx < N-1 → idx + 1, go to GAP.
  - No ack → stay in ISSUE indefinitely (no timeout).
- GAP: `unit_req` = 0 for exactly one cycle, then go to ISSUE.
- DONE: `inst_done` = 1 for exactly one cycle, then go to IDLE.

Rules:
- Acks from unselected units are ignored. Any ack outside the ISSUE state is ignored.
- `inst_valid` in any state other than IDLE is dropped and sets `overrun`. Execution of the current instruction continues unaffected.
- `inst_valid` in the same cycle as DONE counts as an overrun; it is not accepted.
- `illegal` and `overrun` are cleared only by `rst`.
- `unit_arg` and `unit_idx` reflect the instruction register and the iteration index in every state. They are meaningful only while `unit_req` ≠ 0.
- Index arithmetic is 8-bit unsigned. N ≤ 168, so the index never wraps.

## Timing

- Reset values: state IDLE. All outputs are 0: `inst_done`, `rom_en`, `rom_addr`, `unit_req`, `unit_arg`, `unit_idx`, `busy`, `illegal`, `overrun`. The instruction register and latched level are also 0.
- `rst` asserted mid-operation: the next cycle is in IDLE with all outputs at their reset values. No `inst_done` is produced for the aborted instruction.
- All outputs are registered or decoded from state only. None is combinationally dependent on any input.
- Latency, with `inst_valid` accepted in cycle 0:
  - `rom_en` is high in cycle 1.
  - NOP or illegal: `inst_done` is high in cycle 3.
  - ISSUE with an immediate ack: `unit_req` high in cycle 3, ack in cycle 3, `inst_done` in cycle 4.
  - LOOP with immediate acks: 2N + 2 cycles from accept to `inst_done`.
- Cycle counts compatible with the core controller: it pulses `inst_valid` one cycle after IF and waits in EX until `inst_done`.

## Test plan

1. Reset, then ROM[5] = 0x0000 (NOP); pulse `inst_valid` with `pc` = 5 → `rom_addr` = 5 in cycle 1; `inst_done` is high only in cycle 3; `unit_req` stays 0.
2. ROM[0] = 0x1C2A (ISSUE, unit 3, arg 0x02A); unit 3 acks 2 cycles after its request → `unit_req` = 4'b1000 for 3 cycles, `unit_arg` = 0x02A, `unit_idx` = 0; `inst_done` follows one cycle after the ack.
3. ROM[1] = 0x2400 (LOOP, unit 1), level 2, immediate acks → exactly 168 request pulses with `unit_idx` 0..167; each pulse is followed by one GAP cycle except the last; `inst_done` arrives 338 cycles after accept. Repeat with level 1 (122 pulses) and level 3 (80 pulses).
4. ROM[2] = 0x7000 → `illegal` = 1 and `inst_done` in cycle 3; `illegal` remains set across a following NOP; after `rst`, `illegal` = 0.
5. Pulse `inst_valid` during ISSUE, and separately in the DONE cycle → `overrun` = 1; the current instruction completes normally; no second fetch occurs. During ISSUE to unit 0, an ack on unit 2 has no effect.
6. Assert `rst` in the middle of a LOOP at idx 40 → next cycle `unit_req` = 0, `busy` = 0, `unit_idx` = 0, no `inst_done`; a new NOP instruction then executes with nominal latency.
